bus_sequencer: RTL and testbench



---
 rtl/bus_sequencer_pkg.sv | 45 ++++
 rtl/bus_region_decode.sv | 19 +
 rtl/bus_sequencer.sv | 176 +++++++++++++++++
 tb/tb_bus_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sequencer_pkg.sv
// Shared types and constants for the bus sequencer and the memory-map region decode.
package bus_sequencer_pkg;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    localparam logic [3:0] REGION_NIB_ROM = 4'h0;
    localparam logic [3:0] REGION_NIB_RAM = 4'h1;
    localparam logic [3:0] REGION_NIB_IO  = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } t_bus_state;

    typedef enum logic [1:0] {
        REGION_ROM,
        REGION_RAM,
        REGION_IO,
        REGION_NONE
    } t_bus_region;

    // Request payload captured on accept and replayed onto the memory bus.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strobes;
        logic              write;
    } t_bus_req;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter width able to hold max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bus_region_decode.sv
// Maps the top address nibble onto a bus region; shared with the memory map.
module bus_region_decode
    import bus_sequencer_pkg::*;
(
    input  logic [3:0]  nibble_i,
    output t_bus_region region_o
);

    always_comb begin
        region_o = REGION_NONE;
        case (nibble_i)
            REGION_NIB_ROM: region_o = REGION_ROM;
            REGION_NIB_RAM: region_o = REGION_RAM;
            REGION_NIB_IO:  region_o = REGION_IO;
            default:        region_o = REGION_NONE;
        endcase
    end

endmodule

// File: rtl/bus_sequencer.sv
// Runs one timed memory/IO cycle per request from businterface and reports
// completion or bus error; sole driver of the external memory strobes.
module bus_sequencer
    import bus_sequencer_pkg::*;
#(
    parameter int unsigned ROM_WAITS  = 0,
    parameter int unsigned RAM_WAITS  = 1,
    parameter int unsigned IO_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:2] businterface_address,
    input  logic [31:0] businterface_data_out,
    input  logic [3:0]  businterface_data_strobes,
    input  logic        businterface_read,
    input  logic        businterface_write,
    input  logic        businterface_error,
    output logic [31:0] businterface_data_in,
    output logic        bus_done,
    output logic        bus_error,
    output logic [31:2] mem_address,
    output logic [31:0] mem_data_out,
    output logic [3:0]  mem_strobes,
    output logic        mem_read,
    output logic        mem_write,
    output logic        rom_cs,
    output logic        ram_cs,
    output logic        io_cs,
    input  logic [31:0] mem_data_in,
    input  logic        io_ack
);

    localparam int unsigned MAX_WAIT = max3(ROM_WAITS, RAM_WAITS, IO_TIMEOUT);
    localparam int unsigned CNT_W    = cnt_width(MAX_WAIT);

    t_bus_state         state_q;
    t_bus_region        region_q;
    t_bus_req           req_q;
    logic [CNT_W-1:0]   wait_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [STRB_W-1:0]  strobes_q;
    logic               done_q;
    logic               error_q;
    logic               mem_read_q;
    logic               mem_write_q;
    logic               rom_cs_q;
    logic               ram_cs_q;
    logic               io_cs_q;

    t_bus_region        region_c;
    logic               req_valid_c;
    logic               req_err_c;
    logic [CNT_W-1:0]   wait_load_c;
    logic               finish_c;
    logic               fail_c;

    bus_region_decode u_region_decode (
        .nibble_i (businterface_address[31:28]),
        .region_o (region_c)
    );

    // Request qualification and wait-counter preload for the IDLE accept.
    always_comb begin
        req_valid_c = businterface_read | businterface_write;
        req_err_c   = (businterface_read & businterface_write)
                    | businterface_error
                    | (region_c == REGION_NONE)
                    | ((region_c == REGION_ROM) & businterface_write);
        wait_load_c = '0;
        case (region_c)
            REGION_ROM: wait_load_c = CNT_W'(ROM_WAITS);
            REGION_RAM: wait_load_c = CNT_W'(RAM_WAITS);
            REGION_IO:  wait_load_c = CNT_W'(IO_TIMEOUT);
            default:    wait_load_c = '0;
        endcase
    end

    // ACCESS exit: memory ends on counter expiry, IO on ack or timeout (ack wins).
    always_comb begin
        finish_c = 1'b0;
        fail_c   = 1'b0;
        if (region_q == REGION_IO) begin
            if (io_ack) begin
                finish_c = 1'b1;
            end else if (wait_q == '0) begin
                finish_c = 1'b1;
                fail_c   = 1'b1;
            end
        end else if (wait_q == '0) begin
            finish_c = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            region_q    <= REGION_NONE;
            req_q       <= '0;
            wait_q      <= '0;
            rdata_q     <= '0;
            strobes_q   <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rom_cs_q    <= 1'b0;
            ram_cs_q    <= 1'b0;
            io_cs_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_c) begin
                        req_q.addr    <= businterface_address;
                        req_q.data    <= businterface_data_out;
                        req_q.strobes <= businterface_data_strobes;
                        req_q.write   <= businterface_write;
                        region_q      <= region_c;
                        wait_q        <= wait_load_c;
                        if (req_err_c) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                        end else begin
                            state_q     <= ACCESS;
                            strobes_q   <= businterface_data_strobes;
                            mem_read_q  <= businterface_read;
                            mem_write_q <= businterface_write;
                            rom_cs_q    <= (region_c == REGION_ROM);
                            ram_cs_q    <= (region_c == REGION_RAM);
                            io_cs_q     <= (region_c == REGION_IO);
                        end
                    end
                end
                ACCESS: begin
                    if (finish_c) begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        error_q     <= fail_c;
                        strobes_q   <= '0;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        rom_cs_q    <= 1'b0;
                        ram_cs_q    <= 1'b0;
                        io_cs_q     <= 1'b0;
                        if (!fail_c && !req_q.write) begin
                            rdata_q <= mem_data_in;
                        end
                    end else begin
                        wait_q <= wait_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign businterface_data_in = rdata_q;
    assign bus_done             = done_q;
    assign bus_error            = error_q;
    assign mem_address          = req_q.addr;
    assign mem_data_out         = req_q.data;
    assign mem_strobes          = strobes_q;
    assign mem_read             = mem_read_q;
    assign mem_write            = mem_write_q;
    assign rom_cs               = rom_cs_q;
    assign ram_cs               = ram_cs_q;
    assign io_cs                = io_cs_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer: driver queues expected outcomes, a
// negedge monitor checks each bus_done against them.
module tb_bus_sequencer;

    localparam int ROM_W = 0;
    localparam int RAM_W = 1;
    localparam int IO_TO = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic [29:0] businterface_address;
    logic [31:0] businterface_data_out;
    logic [3:0]  businterface_data_strobes;
    logic        businterface_read;
    logic        businterface_write;
    logic        businterface_error;
    logic [31:0] businterface_data_in;
    logic        bus_done;
    logic        bus_error;
    logic [29:0] mem_address;
    logic [31:0] mem_data_out;
    logic [3:0]  mem_strobes;
    logic        mem_read;
    logic        mem_write;
    logic        rom_cs;
    logic        ram_cs;
    logic        io_cs;
    logic [31:0] mem_data_in;
    logic        io_ack;

    bus_sequencer #(
        .ROM_WAITS  (ROM_W),
        .RAM_WAITS  (RAM_W),
        .IO_TIMEOUT (IO_TO)
    ) dut (
        .clock                     (clock),
        .reset                     (reset),
        .businterface_address      (businterface_address),
        .businterface_data_out     (businterface_data_out),
        .businterface_data_strobes (businterface_data_strobes),
        .businterface_read         (businterface_read),
        .businterface_write        (businterface_write),
        .businterface_error        (businterface_error),
        .businterface_data_in      (businterface_data_in),
        .bus_done                  (bus_done),
        .bus_error                 (bus_error),
        .mem_address               (mem_address),
        .mem_data_out              (mem_data_out),
        .mem_strobes               (mem_strobes),
        .mem_read                  (mem_read),
        .mem_write                 (mem_write),
        .rom_cs                    (rom_cs),
        .ram_cs                    (ram_cs),
        .io_cs                     (io_cs),
        .mem_data_in               (mem_data_in),
        .io_ack                    (io_ack)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          act;
        logic [2:0]  cs;
        logic        rd;
        logic        wr;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          done_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] model_rdata = 32'h0;

    always @(posedge clock) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference outcome of one request, from the region/direction rules.
    task automatic model(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic berr, input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [31:0] mdin, input int ack_j, input int k,
                         output exp_t e);
        logic [3:0] nib;
        bit is_rom, is_ram, is_io, imm;
        int lat;
        nib    = addr[31:28];
        is_rom = (nib == 4'h0);
        is_ram = (nib == 4'h1);
        is_io  = (nib == 4'hF);
        imm    = (rd && wr) || berr || !(is_rom || is_ram || is_io) || (is_rom && wr);
        e.addr  = addr[31:2];
        e.wdata = wdata;
        if (imm) begin
            lat = 0; e.err = 1'b1; e.act = 0; e.cs = 3'b000;
            e.rd = 1'b0; e.wr = 1'b0; e.strb = 4'h0;
        end else begin
            e.rd = rd; e.wr = wr; e.strb = strb; e.err = 1'b0;
            if (is_rom) begin
                lat = ROM_W + 1; e.cs = 3'b001;
            end else if (is_ram) begin
                lat = RAM_W + 1; e.cs = 3'b010;
            end else begin
                e.cs = 3'b100;
                if (ack_j > 0) lat = ack_j;
                else begin lat = IO_TO + 1; e.err = 1'b1; end
            end
            e.act = lat;
        end
        if (!e.err && rd) model_rdata = mdin;
        e.rdata    = model_rdata;
        e.done_cyc = k + lat;
    endtask

    task automatic issue(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic berr, input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [31:0] mdin, input int ack_j);
        exp_t e;
        bit   got;
        bit   is_io;
        @(negedge clock);
        businterface_address      = addr[31:2];
        businterface_read         = rd;
        businterface_write        = wr;
        businterface_error        = berr;
        businterface_data_out     = wdata;
        businterface_data_strobes = strb;
        mem_data_in               = mdin;
        is_io = (addr[31:28] == 4'hF);
        model(addr, rd, wr, berr, wdata, strb, mdin, ack_j, cyc + 1, e);
        exp_q.push_back(e);
        got = 0;
        for (int m = 0; m < 40 && !got; m++) begin
            @(negedge clock);
            if (m == 0) begin
                businterface_read  = 1'b0;
                businterface_write = 1'b0;
                businterface_error = 1'b0;
            end
            if (bus_done) got = 1;
            else if (is_io) io_ack = (ack_j == m + 1);
            else io_ack = 1'($urandom_range(0, 1));
        end
        io_ack = 1'b0;
        chk("done_timeout", 64'(got), 64'd1);
    endtask

    // Monitor: tracks active-cycle strobes and scores every bus_done.
    logic [2:0] seen_cs = '0;
    logic       seen_rd = 1'b0;
    logic       seen_wr = 1'b0;
    logic [3:0] snap_strb = '0;
    int         act_cnt = 0;
    logic [2:0] cs_now;
    exp_t       me;

    always @(negedge clock) begin
        cs_now = {io_cs, ram_cs, rom_cs};
        if (reset) begin
            seen_cs = '0; seen_rd = 1'b0; seen_wr = 1'b0; snap_strb = '0; act_cnt = 0;
        end else begin
            chk("cs_onehot", 64'($countones(cs_now) <= 1), 64'd1);
            if (cs_now != 3'b000) begin
                act_cnt++;
                seen_cs   = seen_cs | cs_now;
                seen_rd   = seen_rd | mem_read;
                seen_wr   = seen_wr | mem_write;
                snap_strb = mem_strobes;
            end else begin
                chk("idle_strobes", 64'({mem_read, mem_write, mem_strobes}), 64'd0);
            end
            if (bus_done) begin
                chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    me = exp_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(me.done_cyc));
                    chk("bus_error", 64'(bus_error), 64'(me.err));
                    chk("rdata", 64'(businterface_data_in), 64'(me.rdata));
                    chk("access_clocks", 64'(act_cnt), 64'(me.act));
                    chk("chip_select", 64'(seen_cs), 64'(me.cs));
                    chk("rd_wr", 64'({seen_rd, seen_wr}), 64'({me.rd, me.wr}));
                    chk("mem_address", 64'(mem_address), 64'(me.addr));
                    chk("mem_data_out", 64'(mem_data_out), 64'(me.wdata));
                    chk("mem_strobes", 64'(snap_strb), 64'(me.strb));
                end
                seen_cs = '0; seen_rd = 1'b0; seen_wr = 1'b0; snap_strb = '0; act_cnt = 0;
            end else begin
                chk("error_without_done", 64'(bus_error), 64'd0);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1, e2;
        int   k2, dones;
        logic [31:0] a, d;
        logic [3:0]  nib;
        logic rd, wr, berr;
        int   sel, ack;

        reset = 1'b1;
        businterface_address = '0; businterface_data_out = '0; businterface_data_strobes = '0;
        businterface_read = 1'b0; businterface_write = 1'b0; businterface_error = 1'b0;
        mem_data_in = '0; io_ack = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_ctrl", 64'({bus_done, bus_error, mem_read, mem_write, rom_cs, ram_cs, io_cs}), 64'd0);
        chk("reset_data", 64'({businterface_data_in, mem_data_out}), 64'd0);
        chk("reset_addr_strb", 64'({mem_address, mem_strobes}), 64'd0);
        reset = 1'b0;

        issue(32'h0000_0010, 1, 0, 0, 32'h0, 4'b1111, 32'h1234_5678, 0);
        issue(32'h1000_0004, 0, 1, 0, 32'hABCD_FFFF, 4'b1100, 32'hDEAD_BEEF, 0);
        issue(32'hF000_0000, 1, 0, 0, 32'h0, 4'b0001, 32'h0000_00AA, 3);
        issue(32'hF000_0000, 1, 0, 0, 32'h0, 4'b0001, 32'h0000_0055, 0);
        issue(32'hF000_0100, 0, 1, 0, 32'h1111_2222, 4'b0011, 32'h0, 1);
        issue(32'hF000_0200, 1, 0, 0, 32'h0, 4'b1111, 32'h7777_0001, IO_TO + 1);
        issue(32'h0000_0000, 0, 1, 0, 32'h5555_5555, 4'b1111, 32'h0, 0);
        issue(32'h2000_0000, 1, 0, 0, 32'h0, 4'b1111, 32'h9999_9999, 0);
        issue(32'h1000_0008, 1, 0, 1, 32'h0, 4'b1111, 32'h8888_8888, 0);
        issue(32'h1000_000C, 1, 1, 0, 32'h0, 4'b1111, 32'h6666_6666, 0);

        // Read held through DONE starts a second cycle on the next IDLE clock.
        @(negedge clock);
        businterface_address = 30'h0000_0020; businterface_read = 1'b1;
        businterface_data_strobes = 4'b1111; mem_data_in = 32'hCAFE_0001;
        model(32'h0000_0080, 1, 0, 0, businterface_data_out, 4'b1111, 32'hCAFE_0001, 0, cyc + 1, e1);
        k2 = e1.done_cyc + 2;
        model(32'h0000_0080, 1, 0, 0, businterface_data_out, 4'b1111, 32'hCAFE_0001, 0, k2, e2);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        dones = 0;
        for (int m = 0; m < 40 && dones < 2; m++) begin
            @(negedge clock);
            if (cyc == k2) businterface_read = 1'b0;
            if (bus_done) dones++;
        end
        businterface_read = 1'b0;
        chk("held_dones", 64'(dones), 64'd2);

        // Asynchronous reset in the middle of a RAM read.
        @(negedge clock);
        businterface_address = 30'h0400_0010; businterface_read = 1'b1;
        businterface_data_strobes = 4'b1111; mem_data_in = 32'h0BAD_0BAD;
        @(posedge clock);
        #1;
        chk("pre_reset_ram_cs", 64'(ram_cs), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_async_ctrl", 64'({rom_cs, ram_cs, io_cs, mem_read, mem_write, mem_strobes}), 64'd0);
        chk("rst_async_done", 64'({bus_done, bus_error}), 64'd0);
        chk("rst_async_data_in", 64'(businterface_data_in), 64'd0);
        chk("rst_async_addr", 64'({mem_address, mem_data_out}), 64'd0);
        businterface_read = 1'b0;
        model_rdata = 32'h0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        issue(32'h1000_0040, 1, 0, 0, 32'h0, 4'b0110, 32'h1357_9BDF, 0);

        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 2) nib = 4'h0;
            else if (sel <= 5) nib = 4'h1;
            else if (sel <= 8) nib = 4'hF;
            else nib = 4'($urandom_range(2, 14));
            a = {nib, 26'($urandom), 2'b00};
            if ($urandom_range(0, 9) == 0) begin rd = 1'b1; wr = 1'b1; end
            else begin rd = 1'($urandom_range(0, 1)); wr = ~rd; end
            berr = ($urandom_range(0, 11) == 0);
            ack  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, IO_TO + 1));
            d    = $urandom;
            issue(a, rd, wr, berr, d, 4'($urandom), $urandom, ack);
        end

        repeat (5) @(negedge clock);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
